// File: rtl/mem_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared definitions for the memory-access stage of the 16-bit processor:
// the stage FSM encoding, the word slots of the writeback data bundle and
// the default datapath width.
// -----------------------------------------------------------------------------
package mem_access_stage_pkg;

    localparam int DATA_W   = 16;   // datapath and address width

    // Word slots of the 3-word bundle sent to the writeback buffer.
    localparam int RDATA    = 0;    // data read from memory (0 for stores)
    localparam int ALU      = 1;    // ALU result / memory address
    localparam int RD       = 2;    // destination register, zero-extended
    localparam int WB_WORDS = 3;

    // Width of the bus-timeout counter; covers timeouts of 1..255 cycles.
    localparam int TO_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// -----------------------------------------------------------------------------
// mem_timeout_counter
// Counts enabled cycles since the last clear and flags the cycle in which the
// count would reach LIMIT, so a requester waiting on a bus can abort after
// exactly LIMIT cycles of waiting.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high
//   i_clear    in   restart the count at zero
//   i_enable   in   count this cycle
//   o_expired  out  high in the LIMIT-th consecutive enabled cycle
// -----------------------------------------------------------------------------
module mem_timeout_counter #(
    parameter int CNT_W = 8,
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Compare against LIMIT-1 so the expiry is known in the waiting cycle
    // itself and the requester can leave without an extra dead cycle.
    assign o_expired = i_enable && (r_count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// Memory-access pipeline stage. Non-memory instructions are forwarded to the
// writeback buffer one cycle after they arrive. Loads and stores run a
// req/ack transaction on the data bus while upstream is stalled; the result
// is handed to writeback in a one-cycle DRAIN state. A missing ack aborts the
// access after TIMEOUT cycles and raises a sticky bus_err.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   valid_in, flush               execute result present / kill instruction
//   alu_result, store_data, rd    execute results
//   mem_read_in, mem_write_in,
//   reg_write_in, mem_to_reg_in,
//   pc_src_in                     control bits from execute
//   stall_out                     upstream must hold
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ack data-memory bus
//   wb_load, wb_data              writeback strobe and 3-word bundle
//   pc_src_o, reg_write_o,
//   mem_to_reg_o                  registered control to writeback
//   bus_err                       sticky bus-timeout flag
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int DATA_W  = mem_access_stage_pkg::DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [3:0]            rd,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    input  logic                  pc_src_in,
    output logic                  stall_out,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  wb_load,
    output logic [3*DATA_W-1:0]   wb_data,
    output logic                  pc_src_o,
    output logic                  reg_write_o,
    output logic                  mem_to_reg_o,
    output logic                  bus_err
);

    import mem_access_stage_pkg::*;

    state_t              r_state, w_state_next;
    logic                w_accept_alu, w_start_mem, w_done_ack, w_done_to;
    logic                w_in_access, w_expired, w_kill_now;
    logic                r_killed, r_alu_load, r_bus_err;
    logic                r_mem_req, r_mem_we;
    logic [DATA_W-1:0]   r_mem_addr, r_mem_wdata;
    logic [3:0]          r_p_rd;
    logic                r_p_pc_src, r_p_reg_write, r_p_mem_to_reg;
    logic                r_pc_src_o, r_reg_write_o, r_mem_to_reg_o;
    logic [DATA_W-1:0]   r_wb_word [WB_WORDS];

    assign w_in_access = (r_state == ACCESS);

    mem_timeout_counter #(
        .CNT_W (TO_CNT_W),
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (!w_in_access),
        .i_enable  (w_in_access),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-cycle decisions
    always_comb begin
        w_state_next = r_state;
        w_accept_alu = 1'b0;
        w_start_mem  = 1'b0;
        w_done_ack   = 1'b0;
        w_done_to    = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_in && !flush) begin
                    if (mem_read_in || mem_write_in) begin
                        w_start_mem  = 1'b1;
                        w_state_next = ACCESS;
                    end else begin
                        w_accept_alu = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // An ack wins over a simultaneous expiry: the data is valid.
                if (mem_ack) begin
                    w_done_ack   = 1'b1;
                    w_state_next = DRAIN;
                end else if (w_expired) begin
                    w_done_to    = 1'b1;
                    w_state_next = DRAIN;
                end
            end
            DRAIN:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // A flush in the completing cycle kills just like an earlier one.
    assign w_kill_now = r_killed || flush;

    // Datapath, bus and writeback registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_load     <= 1'b0;
            r_killed       <= 1'b0;
            r_bus_err      <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_p_rd         <= '0;
            r_p_pc_src     <= 1'b0;
            r_p_reg_write  <= 1'b0;
            r_p_mem_to_reg <= 1'b0;
            r_pc_src_o     <= 1'b0;
            r_reg_write_o  <= 1'b0;
            r_mem_to_reg_o <= 1'b0;
            for (int i = 0; i < WB_WORDS; i++) begin
                r_wb_word[i] <= '0;
            end
        end else begin
            r_alu_load <= w_accept_alu;

            if (w_accept_alu) begin
                r_wb_word[RDATA] <= '0;
                r_wb_word[ALU]   <= alu_result;
                r_wb_word[RD]    <= {{(DATA_W-4){1'b0}}, rd};
                r_pc_src_o       <= pc_src_in;
                r_reg_write_o    <= reg_write_in;
                r_mem_to_reg_o   <= mem_to_reg_in;
            end

            if (w_start_mem) begin
                r_mem_req      <= 1'b1;
                r_mem_we       <= mem_write_in;   // read+write behaves as a store
                r_mem_addr     <= alu_result;
                r_mem_wdata    <= store_data;
                r_p_rd         <= rd;
                r_p_pc_src     <= pc_src_in;
                r_p_reg_write  <= reg_write_in;
                r_p_mem_to_reg <= mem_to_reg_in;
                r_killed       <= 1'b0;
            end

            if (w_in_access && flush) begin
                r_killed <= 1'b1;
            end

            if (w_done_ack || w_done_to) begin
                r_mem_req <= 1'b0;
                // Killed instructions leave the writeback bundle untouched.
                if (!w_kill_now) begin
                    r_wb_word[RDATA] <= (w_done_ack && !r_mem_we) ? mem_rdata : '0;
                    r_wb_word[ALU]   <= r_mem_addr;
                    r_wb_word[RD]    <= {{(DATA_W-4){1'b0}}, r_p_rd};
                    r_pc_src_o       <= r_p_pc_src;
                    r_reg_write_o    <= r_p_reg_write && !w_done_to;
                    r_mem_to_reg_o   <= r_p_mem_to_reg;
                end
            end

            if (w_done_to) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // The DRAIN strobe looks at flush directly so a flush arriving during
    // DRAIN still suppresses the writeback.
    assign wb_load = r_alu_load || ((r_state == DRAIN) && !r_killed && !flush);

    generate
        for (genvar gi = 0; gi < WB_WORDS; gi++) begin : g_wb_word
            assign wb_data[gi*DATA_W +: DATA_W] = r_wb_word[gi];
        end
    endgenerate

    assign stall_out    = (r_state != IDLE);
    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign pc_src_o     = r_pc_src_o;
    assign reg_write_o  = r_reg_write_o;
    assign mem_to_reg_o = r_mem_to_reg_o;
    assign bus_err      = r_bus_err;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Self-checking bench for mem_access_stage. Inputs change 1 time unit after
// the rising edge and outputs are sampled on the falling edge. Expectations
// come from a transaction-level view: an ALU op appears one cycle later, a
// memory op holds the bus until ack or TIMEOUT cycles, then writes back once.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

    localparam int W           = 16;
    localparam int TO          = 15;
    localparam int FLUSH_DRAIN = 1000;

    logic            clk = 1'b0;
    logic            reset;
    logic            valid_in, flush;
    logic [W-1:0]    alu_result, store_data;
    logic [3:0]      rd;
    logic            mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in, pc_src_in;
    logic            stall_out, mem_req, mem_we;
    logic [W-1:0]    mem_addr, mem_wdata, mem_rdata;
    logic            mem_ack, wb_load;
    logic [3*W-1:0]  wb_data;
    logic            pc_src_o, reg_write_o, mem_to_reg_o, bus_err;

    int              n_checks = 0;
    int              n_fail   = 0;

    // Reference view of what the writeback buffer should currently hold.
    logic [3*W-1:0]  exp_wb;
    logic [2:0]      exp_ctl;          // {pc_src, reg_write, mem_to_reg}
    bit              known;
    bit              exp_bus_err;

    mem_access_stage #(.DATA_W(W), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .flush         (flush),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .rd            (rd),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .reg_write_in  (reg_write_in),
        .mem_to_reg_in (mem_to_reg_in),
        .pc_src_in     (pc_src_in),
        .stall_out     (stall_out),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .wb_load       (wb_load),
        .wb_data       (wb_data),
        .pc_src_o      (pc_src_o),
        .reg_write_o   (reg_write_o),
        .mem_to_reg_o  (mem_to_reg_o),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in      = 1'b0;
        flush         = 1'b0;
        alu_result    = '0;
        store_data    = '0;
        rd            = '0;
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        reg_write_in  = 1'b0;
        mem_to_reg_in = 1'b0;
        pc_src_in     = 1'b0;
        mem_ack       = 1'b0;
        mem_rdata     = 16'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({stall_out, mem_req, mem_we, mem_addr, mem_wdata, wb_load, wb_data,
             pc_src_o, reg_write_o, mem_to_reg_o, bus_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stall=%b req=%b we=%b addr=%h wdata=%h load=%b data=%h ctl=%b%b%b err=%b expected all zero",
                     stall_out, mem_req, mem_we, mem_addr, mem_wdata, wb_load, wb_data,
                     pc_src_o, reg_write_o, mem_to_reg_o, bus_err);
        end
        reset       = 1'b0;
        exp_wb      = '0;
        exp_ctl     = '0;
        known       = 1'b1;
        exp_bus_err = 1'b0;
        tick();
        $display("txn reset");
    endtask

    task automatic test_reset_mid_access();
        valid_in     = 1'b1;
        mem_read_in  = 1'b1;
        alu_result   = 16'h0080;
        reg_write_in = 1'b1;
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if ({mem_req, stall_out} !== 2'b11) begin
            n_fail++;
            $display("FAIL midreset_access: got req/stall=%b expected 11", {mem_req, stall_out});
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({stall_out, mem_req, mem_we, mem_addr, mem_wdata, wb_load, wb_data,
             pc_src_o, reg_write_o, mem_to_reg_o, bus_err} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got stall=%b req=%b load=%b addr=%h expected all zero",
                     stall_out, mem_req, wb_load, mem_addr);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({wb_load, stall_out, mem_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_after: got load/stall/req=%b expected 000", {wb_load, stall_out, mem_req});
        end
        tick();
        $display("txn reset during ACCESS");
    endtask

    task automatic test_alu(input logic [W-1:0] a, input logic [3:0] d, input logic [2:0] c);
        idle_inputs();
        valid_in = 1'b1;
        alu_result = a;
        rd = d;
        {pc_src_in, reg_write_in, mem_to_reg_in} = c;
        @(negedge clk);
        n_checks++;
        if (stall_out !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_stall: got %b expected 0", stall_out);
        end
        tick();
        idle_inputs();
        exp_wb  = {{12{1'b0}}, d, a, 16'h0000};
        exp_ctl = c;
        known   = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({wb_load, stall_out, bus_err} !== {1'b1, 1'b0, exp_bus_err}) begin
            n_fail++;
            $display("FAIL alu_load: got load/stall/err=%b expected %b", {wb_load, stall_out, bus_err},
                     {1'b1, 1'b0, exp_bus_err});
        end
        n_checks++;
        if ({wb_data, pc_src_o, reg_write_o, mem_to_reg_o} !== {exp_wb, exp_ctl}) begin
            n_fail++;
            $display("FAIL alu_data: got %h/%b expected %h/%b", wb_data, {pc_src_o, reg_write_o, mem_to_reg_o},
                     exp_wb, exp_ctl);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({wb_load, wb_data} !== {1'b0, exp_wb}) begin
            n_fail++;
            $display("FAIL alu_pulse: got load=%b data=%h expected load=0 data=%h", wb_load, wb_data, exp_wb);
        end
        tick();
        $display("txn alu result=%h rd=%0d", a, d);
    endtask

    task automatic test_back_to_back();
        bit exp_load;
        exp_load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bit          v, f;
            logic [W-1:0] a;
            logic [3:0]  d;
            logic [2:0]  c;
            v = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 7) == 0);
            a = 16'($urandom);
            d = 4'($urandom);
            c = 3'($urandom);
            valid_in   = v;
            flush      = f;
            alu_result = a;
            rd         = d;
            store_data = 16'($urandom);
            {pc_src_in, reg_write_in, mem_to_reg_in} = c;
            mem_ack    = 1'($urandom);     // not in ACCESS: must be ignored
            @(negedge clk);
            n_checks++;
            if ({wb_load, stall_out} !== {exp_load, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_load[%0d]: got load/stall=%b expected %b", i, {wb_load, stall_out}, {exp_load, 1'b0});
            end
            if (exp_load || known) begin
                n_checks++;
                if ({wb_data, pc_src_o, reg_write_o, mem_to_reg_o} !== {exp_wb, exp_ctl}) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d]: got %h/%b expected %h/%b", i, wb_data,
                             {pc_src_o, reg_write_o, mem_to_reg_o}, exp_wb, exp_ctl);
                end
            end
            if (v && !f) begin
                exp_load = 1'b1;
                exp_wb   = {{12{1'b0}}, d, a, 16'h0000};
                exp_ctl  = c;
                known    = 1'b1;
                $display("txn alu b2b result=%h rd=%0d", a, d);
            end else begin
                exp_load = 1'b0;
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if ({wb_load, wb_data, pc_src_o, reg_write_o, mem_to_reg_o} !== {exp_load, exp_wb, exp_ctl}) begin
            n_fail++;
            $display("FAIL b2b_last: got %b/%h expected %b/%h", wb_load, wb_data, exp_load, exp_wb);
        end
        tick();
    endtask

    // ack_delay: index of the request cycle carrying mem_ack, or -1 for none.
    // flush_at: request-cycle index to flush in, FLUSH_DRAIN, or -1 for none.
    task automatic mem_txn(input logic rd_op, input logic wr_op,
                           input logic [W-1:0] addr, input logic [W-1:0] wd, input logic [W-1:0] rdat,
                           input logic [3:0] dst, input logic [2:0] ctl,
                           input int ack_delay, input int flush_at);
        int           n_acc;
        bit           killed, timed_out, is_store;
        logic [W-1:0] exp_r;
        is_store  = wr_op;
        timed_out = (ack_delay < 0);
        n_acc     = timed_out ? TO : ack_delay + 1;
        killed    = 1'b0;

        idle_inputs();
        valid_in     = 1'b1;
        mem_read_in  = rd_op;
        mem_write_in = wr_op;
        alu_result   = addr;
        store_data   = wd;
        rd           = dst;
        {pc_src_in, reg_write_in, mem_to_reg_in} = ctl;
        @(negedge clk);
        n_checks++;
        if ({stall_out, mem_req, wb_load} !== 3'b000) begin
            n_fail++;
            $display("FAIL mem_issue: got stall/req/load=%b expected 000", {stall_out, mem_req, wb_load});
        end

        for (int c = 0; c < n_acc; c++) begin
            tick();
            // Upstream noise while stalled must be ignored.
            valid_in      = 1'($urandom);
            alu_result    = 16'($urandom);
            store_data    = 16'($urandom);
            rd            = 4'($urandom);
            mem_read_in   = 1'($urandom);
            mem_write_in  = 1'($urandom);
            reg_write_in  = 1'($urandom);
            flush         = (c == flush_at);
            if (flush) killed = 1'b1;
            mem_ack       = (c == ack_delay);
            mem_rdata     = mem_ack ? rdat : 16'($urandom);
            @(negedge clk);
            n_checks++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, stall_out, wb_load, bus_err} !==
                {1'b1, is_store, addr, wd, 1'b1, 1'b0, exp_bus_err}) begin
                n_fail++;
                $display("FAIL mem_access[%0d]: got req=%b we=%b addr=%h wdata=%h stall=%b load=%b err=%b expected req=1 we=%b addr=%h wdata=%h stall=1 load=0 err=%b",
                         c, mem_req, mem_we, mem_addr, mem_wdata, stall_out, wb_load, bus_err,
                         is_store, addr, wd, exp_bus_err);
            end
        end

        tick();
        idle_inputs();
        mem_ack = 1'($urandom);              // ack outside ACCESS is ignored
        flush   = (flush_at == FLUSH_DRAIN);
        if (flush) killed = 1'b1;
        if (timed_out) exp_bus_err = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mem_req, stall_out, wb_load, bus_err} !== {1'b0, 1'b1, !killed, exp_bus_err}) begin
            n_fail++;
            $display("FAIL mem_drain: got req/stall/load/err=%b expected %b",
                     {mem_req, stall_out, wb_load, bus_err}, {1'b0, 1'b1, !killed, exp_bus_err});
        end
        if (!killed) begin
            exp_r   = (is_store || timed_out) ? 16'h0000 : rdat;
            exp_wb  = {{12{1'b0}}, dst, addr, exp_r};
            exp_ctl = {ctl[2], ctl[1] && !timed_out, ctl[0]};
            known   = 1'b1;
            n_checks++;
            if ({wb_data, pc_src_o, reg_write_o, mem_to_reg_o} !== {exp_wb, exp_ctl}) begin
                n_fail++;
                $display("FAIL mem_wbdata: got %h/%b expected %h/%b", wb_data,
                         {pc_src_o, reg_write_o, mem_to_reg_o}, exp_wb, exp_ctl);
            end
        end else begin
            known = 1'b0;
        end

        tick();
        flush   = 1'b0;
        mem_ack = 1'($urandom);
        @(negedge clk);
        n_checks++;
        if ({stall_out, wb_load, mem_req, bus_err} !== {3'b000, exp_bus_err}) begin
            n_fail++;
            $display("FAIL mem_idle: got stall/load/req/err=%b expected %b",
                     {stall_out, wb_load, mem_req, bus_err}, {3'b000, exp_bus_err});
        end
        tick();
        idle_inputs();
        $display("txn %s addr=%h ack_delay=%0d flush_at=%0d killed=%0b timeout=%0b",
                 is_store ? "store" : "load", addr, ack_delay, flush_at, killed, timed_out);
    endtask

    task automatic test_flush_idle();
        idle_inputs();
        valid_in    = 1'b1;
        flush       = 1'b1;
        mem_read_in = 1'b1;
        alu_result  = 16'h0222;
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if ({stall_out, mem_req, wb_load} !== 3'b000) begin
            n_fail++;
            $display("FAIL flush_idle: got stall/req/load=%b expected 000", {stall_out, mem_req, wb_load});
        end
        tick();
        $display("txn flushed load in IDLE");
    endtask

    task automatic test_ack_ignored();
        idle_inputs();
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        tick();
        mem_ack   = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({stall_out, mem_req, wb_load, wb_data} !== {3'b000, exp_wb}) begin
            n_fail++;
            $display("FAIL ack_ignored: got stall/req/load=%b data=%h expected 000 data=%h",
                     {stall_out, mem_req, wb_load}, wb_data, exp_wb);
        end
        tick();
        idle_inputs();
        $display("txn stray ack in IDLE");
    endtask

    task automatic test_random_mem();
        for (int i = 0; i < 12; i++) begin
            int sel, d, f;
            sel = $urandom_range(0, 2);          // 0 load, 1 store, 2 both (store)
            d   = $urandom_range(0, 6);
            case ($urandom_range(0, 5))
                0:       f = $urandom_range(0, d);
                1:       f = FLUSH_DRAIN;
                default: f = -1;
            endcase
            mem_txn(sel != 1, sel != 0, 16'($urandom), 16'($urandom), 16'($urandom),
                    4'($urandom), 3'($urandom), d, f);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_access();
        test_alu(16'h1234, 4'd5, 3'b010);
        test_back_to_back();
        // load from 0x0040, ack on the third request cycle
        mem_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 4'd3, 3'b011, 2, -1);
        // store 0x00AA to 0x0010, ack on the first request cycle
        mem_txn(1'b0, 1'b1, 16'h0010, 16'h00AA, 16'h5555, 4'd0, 3'b000, 0, -1);
        // store flushed during ACCESS: bus completes, no writeback
        mem_txn(1'b0, 1'b1, 16'h0020, 16'h0077, 16'h1111, 4'd1, 3'b000, 3, 1);
        test_flush_idle();
        test_ack_ignored();
        // no ack at all: abort after TIMEOUT cycles, sticky bus_err
        mem_txn(1'b1, 1'b0, 16'h0100, 16'h0000, 16'hCAFE, 4'd7, 3'b011, -1, -1);
        test_alu(16'h4321, 4'd9, 3'b110);
        test_random_mem();
        test_alu(16'h00FF, 4'd15, 3'b111);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
